alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Covers the same arithmetic and logic classes, plus the following:
  - iterative shifts and a shift-add multiplier;
  - ADC/SBC using a carry held in an architectural NZCV flag register;
  - valid/ready flow control on input and output.
- Sits between the register-file read stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32: operand/result width. Must be a power of 2, at least 8. SHAMT_W = clog2(WIDTH) is a derived localparam.
- MUL_EN, 1: 1 implements MUL. 0 makes opcode 1011 reserved.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B. Low SHAMT_W bits are the shift amount for shifts.
- alu_op  in  4  opcode
- set_flags  in  1  update the flag register when this result retires
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- res_n, res_z, res_c, res_v  out  1 each  flags of this result
- out_err  out  1  opcode was reserved
- flag_n, flag_z, flag_c, flag_v  out  1 each  architectural flag register
- busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; out_valid=0, out_err=0, busy=0.
  - result=0, all res_* = 0, all flag_* = 0; in_ready=1 after release.
  - Any in-flight operation is discarded.
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SUB: A+~B+1
  - 0010 ADC: A+B+Cin
  - 0011 SBC: A+~B+Cin
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
  - 1000 SLL, 1001 SRL, 1010 SRA
  - 1011 MUL: low WIDTH bits, unsigned
  - 1100 PASSA, 1101 PASSB
  - 1110, 1111 reserved
- Flags, arithmetic ops:
  - res_c = carry out of bit WIDTH-1. For SUB/SBC this is "no borrow".
  - res_v = signed overflow.
- Flags, other ops:
  - Logic, PASS and MUL: res_c=0, res_v=0.
  - Shifts: res_c = last bit shifted out (0 when shamt=0); res_v=0.
  - All ops: res_n = result[WIDTH-1]; res_z = (result==0).
- Reserved opcodes: result=0, out_err=1, all res_* = 0, flag register never updated. Latency 1.
- Accept: an operation is taken when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept-on-retire gives back-to-back single-cycle operations.
- States:
  - IDLE -> DONE on accept of a single-cycle op (ADD..NOR, PASS, reserved, or shift with shamt=0). Result is registered, so out_valid rises the cycle after accept (latency 1).
  - IDLE -> BUSY on shift with shamt>0. One bit position per cycle; shamt iterations; out_valid asserted shamt+1 cycles after accept.
  - IDLE -> BUSY on MUL. WIDTH shift-add iterations; out_valid asserted WIDTH+1 cycles after accept.
  - BUSY -> DONE when the iteration count reaches 0. busy=1 only in BUSY; in_ready=0 in BUSY.
  - DONE -> IDLE on out_valid && out_ready with no new accept. With a new accept, go to the next op's state directly.
- Output hold: result, res_*, out_err and out_valid stay stable while out_valid && !out_ready.
- Flag register update:
  - Written from res_* only on the output handshake, and only if the retiring op had set_flags=1 and out_err=0.
  - Otherwise the flag register holds.
- Cin for ADC/SBC is sampled at accept.
  - If a flag-setting op retires in the same cycle, Cin is forwarded from that op's res_c.
  - Otherwise Cin = flag_c.
- Operands, opcode and set_flags are latched at accept. Input changes afterwards have no effect.

Test Plan:
- ADD a=0x7FFFFFFF b=1, set_flags=1 -> out_valid 1 cycle after accept.
  - result=0x80000000, N=1 Z=0 C=0 V=1.
  - flag_* update on the handshake.
- SUB 5-5 with set_flags=1, then back-to-back ADC a=0xFFFFFFFF b=0 accepted on the SUB retire cycle, out_ready held 1.
  - SUB result: 0, Z=1 C=1.
  - ADC uses forwarded Cin=1 -> result=0, Z=1 C=1 V=0.
- SRA a=0x80000010 b=4 -> busy=1 for 4 cycles, in_ready=0, out_valid 5 cycles after accept.
  - result=0xF8000001, res_c=0.
- MUL a=b=0x00010001 -> result=0x00020001 after 33 cycles, C=V=0.
  - With MUL_EN=0, the same op gives out_err=1 and result=0.
- Backpressure: ADD 3+4 with out_ready=0 for 3 cycles.
  - result=7 and out_valid held; in_ready=0.
  - Flags unchanged until the handshake cycle.
- Reset and reserved opcode:
  - Set flags to NZCV=1001, then pulse rst_n low at MUL iteration 10 -> out_valid=0, flags=0000, in_ready=1 after release.
  - Then opcode 1110 with set_flags=1 -> out_err=1, flags stay 0000.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with an NZCV flag register, iterative shifts and a shift-add multiplier.
// Single-cycle ops retire one cycle after accept; shifts (shamt>0) and MUL iterate in BUSY.
module alu_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_n,
    output logic             res_z,
    output logic             res_c,
    output logic             res_v,
    output logic             out_err,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;
    localparam bit          MUL_ON  = (MUL_EN != 0);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_ADC   = 4'h2;
    localparam logic [3:0] OP_SBC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOR   = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_SRL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_PASSA = 4'hC;
    localparam logic [3:0] OP_PASSB = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               setf_q, setf_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         res_q, res_d;     // {n, z, c, v}
    logic [3:0]         flag_q, flag_d;

    logic               hs_c, fl_wr_c, cin_c, accept_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [WIDTH-1:0]   bx_c, sc_res_c;
    logic [WIDTH:0]     sum_c;
    logic               ci_c, sc_c_c, sc_v_c, sc_err_c, multi_c;
    logic [3:0]         sc_flags_c;
    logic [WIDTH-1:0]   it_work_c, it_prod_c, fin_res_c;
    logic               it_bit_c;

    assign hs_c     = (state_q == S_DONE) && out_ready;
    assign fl_wr_c  = hs_c && setf_q && !err_q;
    // Carry-in forwards from a flag-setting op retiring in the same cycle.
    assign cin_c    = fl_wr_c ? res_q[1] : flag_q[1];
    assign in_ready = (state_q == S_IDLE) || hs_c;
    assign accept_c = in_valid && in_ready;
    assign shamt_c  = b[SHAMT_W-1:0];

    // Single-cycle datapath, evaluated on the operands being accepted.
    always_comb begin
        bx_c     = b;
        ci_c     = 1'b0;
        sc_res_c = '0;
        sc_c_c   = 1'b0;
        sc_v_c   = 1'b0;
        sc_err_c = 1'b0;
        multi_c  = 1'b0;
        case (alu_op)
            OP_SUB: begin
                bx_c = ~b;
                ci_c = 1'b1;
            end
            OP_ADC: ci_c = cin_c;
            OP_SBC: begin
                bx_c = ~b;
                ci_c = cin_c;
            end
            default: ;
        endcase
        sum_c = {1'b0, a} + {1'b0, bx_c} + (WIDTH+1)'(ci_c);
        case (alu_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                sc_res_c = sum_c[WIDTH-1:0];
                sc_c_c   = sum_c[WIDTH];
                sc_v_c   = (a[WIDTH-1] == bx_c[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   sc_res_c = a & b;
            OP_OR:    sc_res_c = a | b;
            OP_XOR:   sc_res_c = a ^ b;
            OP_NOR:   sc_res_c = ~(a | b);
            OP_SLL, OP_SRL, OP_SRA: begin
                sc_res_c = a;
                multi_c  = (shamt_c != '0);
            end
            OP_MUL: begin
                if (MUL_ON) multi_c  = 1'b1;
                else        sc_err_c = 1'b1;
            end
            OP_PASSA: sc_res_c = a;
            OP_PASSB: sc_res_c = b;
            default:  sc_err_c = 1'b1;
        endcase
        sc_flags_c = sc_err_c ? 4'b0000
                   : {sc_res_c[WIDTH-1], (sc_res_c == '0), sc_c_c, sc_v_c};
    end

    // One shift position or one shift-add step per BUSY cycle.
    always_comb begin
        it_bit_c  = 1'b0;
        it_work_c = work_q << 1;
        case (op_q)
            OP_SLL: it_bit_c = work_q[WIDTH-1];
            OP_SRL: begin
                it_bit_c  = work_q[0];
                it_work_c = work_q >> 1;
            end
            OP_SRA: begin
                it_bit_c  = work_q[0];
                it_work_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            end
            default: ;
        endcase
        it_prod_c = prod_q + (mplier_q[0] ? work_q : '0);
        fin_res_c = (op_q == OP_MUL) ? it_prod_c : it_work_c;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        setf_d   = setf_q;
        err_d    = err_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        res_d    = res_q;
        flag_d   = fl_wr_c ? res_q : flag_q;

        case (state_q)
            S_BUSY: begin
                work_d   = it_work_c;
                mplier_d = mplier_q >> 1;
                prod_d   = it_prod_c;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = fin_res_c;
                    res_d    = {fin_res_c[WIDTH-1], (fin_res_c == '0),
                                (op_q != OP_MUL) && it_bit_c, 1'b0};
                end
            end
            S_DONE:  if (hs_c) state_d = S_IDLE;
            default: ;
        endcase

        if (accept_c) begin
            op_d   = alu_op;
            setf_d = set_flags;
            if (multi_c) begin
                state_d  = S_BUSY;
                err_d    = 1'b0;
                work_d   = a;
                mplier_d = b;
                prod_d   = '0;
                cnt_d    = (alu_op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt_c);
            end else begin
                state_d  = S_DONE;
                err_d    = sc_err_c;
                result_d = sc_res_c;
                res_d    = sc_flags_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            setf_q   <= 1'b0;
            err_q    <= 1'b0;
            work_q   <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            res_q    <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            setf_q   <= setf_d;
            err_q    <= err_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;
    assign out_err   = err_q;
    assign {res_n, res_z, res_c, res_v}     = res_q;
    assign {flag_n, flag_z, flag_c, flag_v} = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: latency, results, NZCV, forwarding, backpressure, reset and MUL_EN=0.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   alu_op;
    logic         set_flags;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         res_n, res_z, res_c, res_v, out_err;
    logic         flag_n, flag_z, flag_c, flag_v, busy;

    logic         nm_valid, nm_in_ready, nm_out_valid;
    logic [W-1:0] nm_result;
    logic         nm_res_n, nm_res_z, nm_res_c, nm_res_v, nm_out_err;
    logic         nm_flag_n, nm_flag_z, nm_flag_c, nm_flag_v, nm_busy;

    logic [3:0]   res_f, flag_f, nm_res_f, nm_flag_f, flag_m;
    int           n_checks = 0;
    int           n_errs   = 0;

    assign res_f     = {res_n, res_z, res_c, res_v};
    assign flag_f    = {flag_n, flag_z, flag_c, flag_v};
    assign nm_res_f  = {nm_res_n, nm_res_z, nm_res_c, nm_res_v};
    assign nm_flag_f = {nm_flag_n, nm_flag_z, nm_flag_c, nm_flag_v};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v), .out_err(out_err),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(0)) u_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(nm_valid), .in_ready(nm_in_ready),
        .a(a), .b(b), .alu_op(alu_op), .set_flags(set_flags),
        .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result),
        .res_n(nm_res_n), .res_z(nm_res_z), .res_c(nm_res_c), .res_v(nm_res_v),
        .out_err(nm_out_err), .flag_n(nm_flag_n), .flag_z(nm_flag_z),
        .flag_c(nm_flag_c), .flag_v(nm_flag_v), .busy(nm_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer one op with out_ready=1, measure latency, check outputs and the flag register.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sf, input logic [W-1:0] e_res, input logic [3:0] e_f,
                          input logic e_err, input int e_lat);
        int lat;
        alu_op = op; a = av; b = bv; set_flags = sf; out_ready = 1'b1; in_valid = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("busy", 64'(busy), 64'(1));
            check("in_ready_busy", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(e_lat));
        check("result", 64'(result), 64'(e_res));
        check("res_nzcv", 64'(res_f), 64'(e_f));
        check("out_err", 64'(out_err), 64'(e_err));
        check("flags_before_hs", 64'(flag_f), 64'(flag_m));
        @(posedge clk); #1;
        if (sf && !e_err) flag_m = e_f;
        check("flags_after_hs", 64'(flag_f), 64'(flag_m));
        check("out_valid_retired", 64'(out_valid), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; nm_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_op = 4'h0; set_flags = 1'b0; flag_m = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_res", 64'(res_f), 64'(0));
        check("rst_flags", 64'(flag_f), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // MUL_EN=0: MUL is reserved
        alu_op = 4'hB; a = 32'h0001_0001; b = 32'h0001_0001; set_flags = 1'b1; nm_valid = 1'b1;
        @(posedge clk); #1;
        nm_valid = 1'b0;
        check("nomul_valid", 64'(nm_out_valid), 64'(1));
        check("nomul_err", 64'(nm_out_err), 64'(1));
        check("nomul_result", 64'(nm_result), 64'(0));
        check("nomul_res", 64'(nm_res_f), 64'(0));
        @(posedge clk); #1;
        check("nomul_flags", 64'(nm_flag_f), 64'(0));

        // op, a, b, set_flags, result, NZCV, err, latency
        run_op(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001, 1'b0, 1);
        run_op(4'h2, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b0000, 1'b0, 1);
        run_op(4'h1, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1);
        run_op(4'h1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b0, 1);
        run_op(4'h1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b0110, 1'b0, 1);
        run_op(4'h3, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110, 1'b0, 1);
        run_op(4'h2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0110, 1'b0, 1);
        run_op(4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0100, 1'b0, 1);
        run_op(4'h3, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1);
        run_op(4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b1000, 1'b0, 1);
        run_op(4'h5, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b0, 1);
        run_op(4'h6, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555, 4'b0000, 1'b0, 1);
        run_op(4'h7, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1);
        run_op(4'hC, 32'h8000_0000, 32'h1234_5678, 1'b0, 32'h8000_0000, 4'b1000, 1'b0, 1);
        run_op(4'hD, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b0, 1);
        run_op(4'h8, 32'h8000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b0010, 1'b0, 2);
        run_op(4'h9, 32'h1234_5678, 32'h0000_0020, 1'b0, 32'h1234_5678, 4'b0000, 1'b0, 1);
        run_op(4'hA, 32'h8000_0010, 32'h0000_0004, 1'b0, 32'hF800_0001, 4'b1000, 1'b0, 5);
        run_op(4'h9, 32'h8000_0000, 32'h0000_001F, 1'b0, 32'h0000_0001, 4'b0000, 1'b0, 32);
        run_op(4'hB, 32'h0001_0001, 32'h0001_0001, 1'b0, 32'h0002_0001, 4'b0000, 1'b0, 33);
        run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 4'b0000, 1'b0, 33);
        run_op(4'hF, 32'h1234_5678, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0000, 1'b1, 1);

        // Back-to-back: ADC accepted on the SUB retire cycle takes the forwarded carry
        alu_op = 4'h1; a = 32'd5; b = 32'd5; set_flags = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_sub_valid", 64'(out_valid), 64'(1));
        check("b2b_sub_result", 64'(result), 64'(0));
        check("b2b_sub_res", 64'(res_f), 64'(4'b0110));
        alu_op = 4'h2; a = 32'hFFFF_FFFF; b = 32'h0;
        check("b2b_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        flag_m = 4'b0110;
        check("b2b_flags_sub", 64'(flag_f), 64'(flag_m));
        check("b2b_adc_valid", 64'(out_valid), 64'(1));
        check("b2b_adc_result", 64'(result), 64'(0));
        check("b2b_adc_res", 64'(res_f), 64'(4'b0110));
        @(posedge clk); #1;
        check("b2b_flags_adc", 64'(flag_f), 64'(flag_m));
        check("b2b_retired", 64'(out_valid), 64'(0));

        // Backpressure: result held, later input changes ignored, flags wait for handshake
        alu_op = 4'h0; a = 32'd3; b = 32'd4; set_flags = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'd100; b = 32'd200; alu_op = 4'h1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_result", 64'(result), 64'(7));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_flags_hold", 64'(flag_f), 64'(flag_m));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("bp_res", 64'(res_f), 64'(4'b0000));
        check("bp_result_hs", 64'(result), 64'(7));
        @(posedge clk); #1;
        flag_m = 4'b0000;
        check("bp_flags_upd", 64'(flag_f), 64'(flag_m));
        check("bp_retired", 64'(out_valid), 64'(0));

        // Reset during MUL discards it and clears the flags
        run_op(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001, 1'b0, 1);
        alu_op = 4'hB; a = 32'h0001_0001; b = 32'h0001_0001; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mul_busy_pre_rst", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        flag_m = 4'b0000;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_flags", 64'(flag_f), 64'(flag_m));
        check("arst_result", 64'(result), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("arst_in_ready", 64'(in_ready), 64'(1));
        repeat (35) @(posedge clk);
        #1;
        check("arst_discarded", 64'(out_valid), 64'(0));
        run_op(4'hE, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h0000_0000, 4'b0000, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
